fifo36e2_seq_ctrl: RTL

- Single-clock controller for one common-clock, first-word-fall-through FIFO36E2 wrapper instance.
- Sequences the primitive's reset protocol: assert reset for a minimum number of cycles, wait for both reset-busy flags to clear, then settle.
- Gates write and read enables so they are never issued during reset-busy, full or empty.
- Presents ready/valid enqueue/dequeue handshakes, an occupancy count and a sticky reset-timeout error to the surrounding logic.

---
 rtl/fifo36e2_seq_ctrl_if.sv | 22 ++
 rtl/fifo36e2_seq_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/fifo36e2_seq_ctrl_if.sv
// Enqueue/dequeue ready/valid handshake between the surrounding logic and the FIFO controller.
// master = the user side producing/consuming words, slave = the controller.
interface fifo36e2_seq_ctrl_if;
  logic enq_valid;
  logic enq_ready;
  logic deq_valid;
  logic deq_ready;

  modport master (
    output enq_valid,
    output deq_ready,
    input  enq_ready,
    input  deq_valid
  );

  modport slave (
    input  enq_valid,
    input  deq_ready,
    output enq_ready,
    output deq_valid
  );
endinterface

// File: rtl/fifo36e2_seq_ctrl.sv
// Reset sequencer and enable gating for a common-clock FWFT FIFO36E2 wrapper:
// ASSERT -> WAIT (busy flags) -> SETTLE -> RUN, with occupancy count and sticky timeout flag.
module fifo36e2_seq_ctrl #(
  parameter int unsigned RST_CYCLES    = 5,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned TIMEOUT       = 1024,
  parameter int unsigned DEPTH         = 512,
  parameter int unsigned CW            = $clog2(DEPTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  clr,
  fifo36e2_seq_ctrl_if.slave    hs,
  output logic                  fifo_rst_n,
  output logic                  fifo_wren,
  output logic                  fifo_rden,
  input  logic                  fifo_empty_n,
  input  logic                  fifo_full_n,
  input  logic                  fifo_rdrstbusy,
  input  logic                  fifo_wrrstbusy,
  output logic                  ready,
  output logic [CW-1:0]         count,
  output logic                  err_timeout
);

  localparam int PW = 16;

  typedef enum logic [1:0] {
    StAssert,
    StWait,
    StSettle,
    StRun
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [CW-1:0]   count_q, count_d;
  logic            err_q, err_d;
  logic            enq_ready_c, deq_valid_c;
  logic            any_busy;

  assign any_busy = fifo_rdrstbusy | fifo_wrrstbusy;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StAssert;
      phase_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    phase_d = phase_q + 1'b1;
    count_d = count_q;
    err_d   = err_q;
    unique case (state_q)
      StAssert: begin
        if (phase_q == PW'(RST_CYCLES - 1)) begin
          state_d = StWait;
          phase_d = '0;
        end
      end
      StWait: begin
        // Busy rises only after the reset edge, so the first WAIT cycle never exits.
        if ((phase_q != '0) && !any_busy) begin
          state_d = (SETTLE_CYCLES == 0) ? StRun : StSettle;
          phase_d = '0;
        end else if (phase_q == PW'(TIMEOUT - 1)) begin
          state_d = StAssert;
          phase_d = '0;
          err_d   = 1'b1;
        end
      end
      StSettle: begin
        if (phase_q == PW'(SETTLE_CYCLES - 1)) begin
          state_d = StRun;
          phase_d = '0;
        end
      end
      StRun: begin
        phase_d = '0;
        if (fifo_wren && !fifo_rden) begin
          count_d = (count_q == CW'(DEPTH)) ? count_q : count_q + 1'b1;
        end else if (fifo_rden && !fifo_wren) begin
          count_d = (count_q == '0) ? count_q : count_q - 1'b1;
        end
        // Handshakes qualified this cycle still complete; the flush clears the count.
        if (clr) begin
          state_d = StAssert;
          count_d = '0;
        end
      end
      default: begin
        state_d = StAssert;
        phase_d = '0;
        count_d = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    fifo_rst_n  = (state_q != StAssert);
    ready       = (state_q == StRun);
    enq_ready_c = ready & fifo_full_n & ~fifo_wrrstbusy;
    deq_valid_c = ready & fifo_empty_n & ~fifo_rdrstbusy;
    fifo_wren   = hs.enq_valid & enq_ready_c;
    fifo_rden   = deq_valid_c & hs.deq_ready;
  end

  assign hs.enq_ready = enq_ready_c;
  assign hs.deq_valid = deq_valid_c;
  assign count        = count_q;
  assign err_timeout  = err_q;

`ifndef SYNTHESIS
  a_count_overflow : assert property (@(posedge CLK) disable iff (RST)
    !(fifo_wren && !fifo_rden && (count_q == CW'(DEPTH))));
  a_count_underflow : assert property (@(posedge CLK) disable iff (RST)
    !(fifo_rden && !fifo_wren && (count_q == '0)));
`endif

endmodule
